// File: rtl/grid_pkg.sv
// Shared types and default dimensions for the playfield grid engine.
package grid_pkg;

  // Line-check pass sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_FINISH
  } grid_state_e;

  // Default playfield geometry
  localparam int DEF_WIDTH    = 10;
  localparam int DEF_HEIGHT   = 20;
  localparam int DEF_COLOUR_W = 3;
  localparam int DEF_TOP_ROWS = 2;
  localparam int DEF_SCORE_W  = 16;

  // Cell value meaning "nothing here"
  localparam int EMPTY_CELL = 0;

endpackage

// File: rtl/row_full_detect.sv
// Reduction over a flattened vector of cells.
// ANY=0: output high when every cell is occupied (full row test).
// ANY=1: output high when at least one cell is occupied (zone test).
module row_full_detect
  import grid_pkg::*;
#(
  parameter int CELLS    = DEF_WIDTH,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter bit ANY      = 1'b0
) (
  input  logic [CELLS*COLOUR_W-1:0] row,
  output logic                      full
);

  logic [CELLS-1:0] occ;

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign occ[i] = (row[i*COLOUR_W +: COLOUR_W] != COLOUR_W'(EMPTY_CELL));
  end

  assign full = ANY ? (|occ) : (&occ);

endmodule

// File: rtl/playfield_grid_engine.sv
// Playfield store: cell writes from block lock, combinational reads for the
// draw path, and a line-check pass that removes full rows bottom-up.
// Optional feature macro: GRID_SCORE_EN (score = sum of lines^2, saturating).
module playfield_grid_engine
  import grid_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int TOP_ROWS = DEF_TOP_ROWS,
  parameter int SCORE_W  = DEF_SCORE_W,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int LW = $clog2(HEIGHT + 1)
) (
  input  logic                Clk,
  input  logic                RST,
  input  logic                wr_en,
  input  logic [XW-1:0]       wr_x,
  input  logic [YW-1:0]       wr_y,
  input  logic [COLOUR_W-1:0] wr_colour,
  input  logic [XW-1:0]       rd_x,
  input  logic [YW-1:0]       rd_y,
  output logic [COLOUR_W-1:0] rd_colour,
  input  logic                clr_all,
  input  logic                chk_start,
  output logic                busy,
  output logic                done,
  output logic [LW-1:0]       lines,
  output logic                game_over,
  output logic [SCORE_W-1:0]  score
);

  localparam int ROW_W = WIDTH * COLOUR_W;

  grid_state_e                   state;
  logic [HEIGHT-1:0][ROW_W-1:0]  grid;
  logic [YW-1:0]                 r;
  logic [LW-1:0]                 cnt;
  logic [HEIGHT-1:0]             row_full;
  logic                          zone_occ;
  logic                          cur_full;
  logic                          fin_go;

  // One full-row detector per row; the scan just picks the one at r
  for (genvar k = 0; k < HEIGHT; k++) begin : g_row
    row_full_detect #(.CELLS(WIDTH), .COLOUR_W(COLOUR_W), .ANY(1'b0)) u_row (
      .row  (grid[k]),
      .full (row_full[k])
    );
  end

  // Any occupied cell in the top rows means the stack reached the spawn area
  row_full_detect #(.CELLS(WIDTH*TOP_ROWS), .COLOUR_W(COLOUR_W), .ANY(1'b1)) u_zone (
    .row  (grid[TOP_ROWS-1:0]),
    .full (zone_occ)
  );

  assign cur_full = row_full[r];
  // Last scan step: top row tested and not full, pass ends next cycle
  assign fin_go   = (state == ST_SCAN) && !cur_full && (r == '0);

  // Read mux; addresses outside the grid match nothing and return empty
  always_comb begin
    rd_colour = '0;
    for (int k = 0; k < HEIGHT; k++)
      for (int c = 0; c < WIDTH; c++)
        if (rd_y == YW'(k) && rd_x == XW'(c))
          rd_colour = grid[k][c*COLOUR_W +: COLOUR_W];
  end

  // Pass sequencer plus grid storage; clr_all overrides everything but reset
  always_ff @(posedge Clk) begin
    if (!RST || clr_all) begin
      state     <= ST_IDLE;
      grid      <= '0;
      r         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lines     <= '0;
      game_over <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!game_over) begin
            // Write first so a same-cycle check sees the locked piece
            if (wr_en)
              for (int k = 0; k < HEIGHT; k++)
                for (int c = 0; c < WIDTH; c++)
                  if (wr_y == YW'(k) && wr_x == XW'(c))
                    grid[k][c*COLOUR_W +: COLOUR_W] <= wr_colour;
            if (chk_start) begin
              r     <= YW'(HEIGHT - 1);
              cnt   <= '0;
              busy  <= 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (cur_full) begin
            state <= ST_SHIFT;
          end else if (r != '0) begin
            r <= r - YW'(1);
          end else begin
            // Grid is final here, so the finish results are registered now
            // and are visible during the FINISH cycle alongside done
            busy      <= 1'b0;
            done      <= 1'b1;
            lines     <= cnt;
            game_over <= zone_occ;
            state     <= ST_FINISH;
          end
        end
        ST_SHIFT: begin
          // Drop everything above r by one row; r is rescanned afterwards
          for (int k = 1; k < HEIGHT; k++)
            if (YW'(k) <= r)
              grid[k] <= grid[k-1];
          grid[0] <= '0;
          cnt     <= cnt + LW'(1);
          state   <= ST_SCAN;
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GRID_SCORE_EN
  logic [2*LW-1:0]  sq;
  logic [SCORE_W:0] sum;

  assign sq  = {{LW{1'b0}}, cnt} * {{LW{1'b0}}, cnt};
  assign sum = {1'b0, score} + (SCORE_W+1)'(sq);

  // Accumulate lines^2 when the pass ends, clamping at all-ones
  always_ff @(posedge Clk) begin
    if (!RST || clr_all)
      score <= '0;
    else if (fin_go)
      score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_playfield_grid_engine.sv
// Scoreboard bench for playfield_grid_engine: the driver pushes expected
// read/status/pass results, a negedge monitor pops and compares them.
module tb_playfield_grid_engine;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 3;
  localparam int TR = 2;
  localparam int SW = 16;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int LW = $clog2(H + 1);
`ifdef GRID_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          RST = 1'b0;
  logic          wr_en = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [YW-1:0] wr_y = '0;
  logic [CW-1:0] wr_colour = '0;
  logic [XW-1:0] rd_x = '0;
  logic [YW-1:0] rd_y = '0;
  logic [CW-1:0] rd_colour;
  logic          clr_all = 1'b0;
  logic          chk_start = 1'b0;
  logic          busy, done, game_over;
  logic [LW-1:0] lines;
  logic [SW-1:0] score;

  playfield_grid_engine #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(CW), .TOP_ROWS(TR), .SCORE_W(SW)) dut (
    .Clk(Clk), .RST(RST), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour),
    .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour), .clr_all(clr_all), .chk_start(chk_start),
    .busy(busy), .done(done), .lines(lines), .game_over(game_over), .score(score)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct packed { logic [XW-1:0] x; logic [YW-1:0] y; logic [CW-1:0] c; } rd_t;
  typedef struct packed { logic b; logic d; logic [LW-1:0] l; logic g; logic [SW-1:0] s; } st_t;
  typedef struct packed { logic [LW-1:0] l; logic g; logic [SW-1:0] s; } dn_t;

  rd_t rq[$];
  st_t sq[$];
  dn_t dq[$];
  logic rd_req = 1'b0;
  logic st_req = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   eg[H][W];

  // Monitor: compares whatever the DUT presents against the queued expectation
  initial begin
    int age;
    age = 0;
    forever begin
      @(negedge Clk);
      if (rd_req && rq.size() > 0) begin
        rd_t e;
        e = rq.pop_front();
        checks++;
        if (rd_colour !== e.c) begin
          errors++;
          $display("FAIL rd(%0d,%0d) got %0d want %0d", e.x, e.y, rd_colour, e.c);
        end
      end
      if (st_req && sq.size() > 0) begin
        st_t e;
        e = sq.pop_front();
        checks++;
        if ({busy, done, lines, game_over, score} !== e) begin
          errors++;
          $display("FAIL status got b%0d d%0d l%0d g%0d s%0d want b%0d d%0d l%0d g%0d s%0d",
                   busy, done, lines, game_over, score, e.b, e.d, e.l, e.g, e.s);
        end
      end
      if (done === 1'b1) begin
        checks++;
        age = 0;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got done=1 want no pulse");
        end else begin
          dn_t e;
          e = dq.pop_front();
          if ({lines, game_over, score} !== e) begin
            errors++;
            $display("FAIL pass_result got l%0d g%0d s%0d want l%0d g%0d s%0d",
                     lines, game_over, score, e.l, e.g, e.s);
          end
        end
      end else if (dq.size() > 0) begin
        age++;
        if (age > 60) begin
          checks++;
          errors++;
          $display("FAIL done_timeout got no done in 60 cycles want l%0d", dq[0].l);
          void'(dq.pop_front());
          age = 0;
        end
      end
    end
  end

  function automatic int sc(input int v);
    return SCORE_ON ? v : 0;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input int c);
    wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_colour = CW'(c);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input int c);
    rd_t e;
    e.x = XW'(x); e.y = YW'(y); e.c = CW'(c);
    rq.push_back(e);
    rd_x = XW'(x); rd_y = YW'(y); rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic stat(input bit b, input bit d, input int l, input bit g, input int s);
    st_t e;
    e.b = b; e.d = d; e.l = LW'(l); e.g = g; e.s = SW'(s);
    sq.push_back(e);
    st_req = 1'b1;
    cyc();
    st_req = 1'b0;
  endtask

  // Start a pass with the expected outcome queued; optional same-cycle write
  task automatic start_chk(input bit we, input int x, input int y, input int c,
                           input int l, input bit g, input int s);
    dn_t e;
    e.l = LW'(l); e.g = g; e.s = SW'(s);
    dq.push_back(e);
    wr_en = we; wr_x = XW'(x); wr_y = YW'(y); wr_colour = CW'(c);
    chk_start = 1'b1;
    cyc();
    chk_start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (done === 1'b1) break;
    end
    cyc();
  endtask

  task automatic clear_eg();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        eg[y][x] = 0;
  endtask

  task automatic check_grid();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        rd(x, y, eg[y][x]);
  endtask

  task automatic fill_row(input int y, input int c);
    for (int x = 0; x < W; x++) wr(x, y, c);
  endtask

  initial begin
    // 1. reset for one edge
    cyc();
    RST = 1'b1;
    stat(0, 0, 0, 0, 0);
    clear_eg();
    check_grid();

    // 2. one full row, marker above it; last cell written with chk_start
    for (int x = 0; x < W - 1; x++) wr(x, 19, 3);
    wr(0, 18, 5);
    start_chk(1'b1, 9, 19, 3, 1, 1'b0, sc(1));
    wait_done();
    stat(0, 0, 1, 0, sc(1));
    clear_eg();
    eg[19][0] = 5;
    check_grid();

    // 3. four full rows at the bottom
    for (int y = 16; y < 20; y++) fill_row(y, 7);
    start_chk(1'b0, 0, 0, 0, 4, 1'b0, sc(17));
    wait_done();
    clear_eg();
    check_grid();

    // 4. two non-adjacent full rows; a write during the pass is dropped
    fill_row(19, 4);
    fill_row(17, 4);
    wr(3, 18, 2);
    start_chk(1'b0, 0, 0, 0, 2, 1'b0, sc(21));
    wr(5, 5, 3);
    wait_done();
    stat(0, 0, 2, 0, sc(21));
    clear_eg();
    eg[19][3] = 2;
    check_grid();

    // 5. piece in the top zone -> game over, then writes/checks are ignored
    wr(4, 1, 6);
    start_chk(1'b0, 0, 0, 0, 0, 1'b1, sc(21));
    wait_done();
    wr(0, 19, 1);
    rd(0, 19, 0);
    chk_start = 1'b1;
    cyc();
    chk_start = 1'b0;
    stat(0, 0, 0, 1, sc(21));
    rd(4, 1, 6);
    rd(3, 19, 2);
    clr_all = 1'b1;
    cyc();
    clr_all = 1'b0;
    stat(0, 0, 0, 0, 0);
    clear_eg();
    check_grid();

    // 6. abort a pass with clr_all; no done pulse may follow
    fill_row(19, 1);
    chk_start = 1'b1;
    cyc();
    chk_start = 1'b0;
    stat(1, 0, 0, 0, 0);
    repeat (3) cyc();
    clr_all = 1'b1;
    cyc();
    clr_all = 1'b0;
    stat(0, 0, 0, 0, 0);
    repeat (40) cyc();
    wr(12, 3, 5);
    wr(2, 25, 5);
    wr(15, 19, 5);
    rd(12, 3, 0);
    rd(0, 25, 0);
    clear_eg();
    check_grid();

    repeat (70) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
